// File: rtl/multiport_ram_2r2w.sv
// -----------------------------------------------------------------------------
// multiport_ram_2r2w
//
// Two-read, two-write synchronous RAM used by the value predictor for its
// last-value and confidence tables. Reads come from the prediction path,
// writes from the update path. Read data is registered (1-cycle latency) and
// write-first: a read of a word written on the same edge returns the new data.
// When both writes hit the same word, port B's data is kept.
//
// Parameters
//   P_MEM_DEPTH  number of words (>= 2, need not be a power of two)
//   P_MEM_WIDTH  word width in bits
//   P_SIM        1 = every word is a resettable flop
//                0 = plain data array plus per-word valid bits
//   P_METHOD     "MULTIPUMPED" : one array updated by A then B each cycle
//                "LVT"         : one bank per write port plus a live-value
//                                table recording which bank holds each word
//
// Ports
//   clk_i, rst_i              clock, asynchronous active-high reset
//   rda_addr_i / rda_data_o   read port A address / registered data
//   rdb_addr_i / rdb_data_o   read port B address / registered data
//   wra_addr_i/_data_i/_valid_i  write port A
//   wrb_addr_i/_data_i/_valid_i  write port B
//
// Addresses >= P_MEM_DEPTH are invalid: writes are dropped, reads return 0.
// -----------------------------------------------------------------------------

// Storage array with two write ports (B applied after A) and two
// combinational read ports. Callers guarantee write addresses are in range.
//
// Ports
//   i_clk, i_rst                    clock, asynchronous active-high reset
//   i_wa_en/_addr/_data             write port A
//   i_wb_en/_addr/_data             write port B (wins over A on same word)
//   i_ra_addr/o_ra_data             combinational read port A
//   i_rb_addr/o_rb_data             combinational read port B
module multiport_ram_2r2w_store #(
    parameter int P_DEPTH = 2048,
    parameter int P_WIDTH = 32,
    parameter int P_AW    = 11,
    parameter bit P_SIM   = 1'b1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_wa_en,
    input  logic [P_AW-1:0]    i_wa_addr,
    input  logic [P_WIDTH-1:0] i_wa_data,
    input  logic               i_wb_en,
    input  logic [P_AW-1:0]    i_wb_addr,
    input  logic [P_WIDTH-1:0] i_wb_data,
    input  logic [P_AW-1:0]    i_ra_addr,
    input  logic [P_AW-1:0]    i_rb_addr,
    output logic [P_WIDTH-1:0] o_ra_data,
    output logic [P_WIDTH-1:0] o_rb_data
);

    logic [P_WIDTH-1:0] r_mem [P_DEPTH];

    if (P_SIM) begin : g_flop
        // NOTE: sequential state uses non-blocking assignments so that both
        // write ports and every reader see the pre-edge values consistently;
        // the later B assignment overrides A when the addresses match.
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                for (int i = 0; i < P_DEPTH; i++) begin
                    r_mem[i] <= '0;
                end
            end else begin
                if (i_wa_en) r_mem[i_wa_addr] <= i_wa_data;
                if (i_wb_en) r_mem[i_wb_addr] <= i_wb_data;
            end
        end

        assign o_ra_data = r_mem[i_ra_addr];
        assign o_rb_data = r_mem[i_rb_addr];
    end else begin : g_array
        logic [P_DEPTH-1:0] r_valid;

        // NOTE: the data array carries no reset so it can map onto RAM
        // macros; a cleared valid bit makes a word read as zero instead.
        // Writes are still blocked while reset is held.
        always_ff @(posedge i_clk) begin
            if (!i_rst) begin
                if (i_wa_en) r_mem[i_wa_addr] <= i_wa_data;
                if (i_wb_en) r_mem[i_wb_addr] <= i_wb_data;
            end
        end

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                r_valid <= '0;
            end else begin
                if (i_wa_en) r_valid[i_wa_addr] <= 1'b1;
                if (i_wb_en) r_valid[i_wb_addr] <= 1'b1;
            end
        end

        assign o_ra_data = r_valid[i_ra_addr] ? r_mem[i_ra_addr] : '0;
        assign o_rb_data = r_valid[i_rb_addr] ? r_mem[i_rb_addr] : '0;
    end

endmodule

module multiport_ram_2r2w #(
    parameter int    P_MEM_DEPTH  = 2048,
    parameter int    P_MEM_WIDTH  = 32,
    parameter int    P_SIM        = 1,
    parameter string P_METHOD     = "MULTIPUMPED",
    localparam int   P_ADDR_WIDTH = $clog2(P_MEM_DEPTH)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [P_ADDR_WIDTH-1:0] rda_addr_i,
    input  logic [P_ADDR_WIDTH-1:0] rdb_addr_i,
    output logic [P_MEM_WIDTH-1:0]  rda_data_o,
    output logic [P_MEM_WIDTH-1:0]  rdb_data_o,
    input  logic [P_ADDR_WIDTH-1:0] wra_addr_i,
    input  logic [P_MEM_WIDTH-1:0]  wra_data_i,
    input  logic                    wra_valid_i,
    input  logic [P_ADDR_WIDTH-1:0] wrb_addr_i,
    input  logic [P_MEM_WIDTH-1:0]  wrb_data_i,
    input  logic                    wrb_valid_i
);

    // One extra bit so a power-of-two depth is representable.
    localparam logic [P_ADDR_WIDTH:0] L_DEPTH = (P_ADDR_WIDTH + 1)'(P_MEM_DEPTH);

    logic                   w_rda_ok;
    logic                   w_rdb_ok;
    logic                   w_wa_en;
    logic                   w_wb_en;
    logic [P_MEM_WIDTH-1:0] w_rda_store;
    logic [P_MEM_WIDTH-1:0] w_rdb_store;
    logic [P_MEM_WIDTH-1:0] w_rda_next;
    logic [P_MEM_WIDTH-1:0] w_rdb_next;

    assign w_rda_ok = ({1'b0, rda_addr_i} < L_DEPTH);
    assign w_rdb_ok = ({1'b0, rdb_addr_i} < L_DEPTH);

    // Port A is suppressed when B writes the same word, so the storage never
    // sees two writes to one address and B's data is the one kept.
    assign w_wb_en = wrb_valid_i && ({1'b0, wrb_addr_i} < L_DEPTH);
    assign w_wa_en = wra_valid_i && ({1'b0, wra_addr_i} < L_DEPTH)
                     && !(w_wb_en && (wra_addr_i == wrb_addr_i));

    if (P_METHOD == "MULTIPUMPED") begin : g_multipumped
        // Single array taking A then B in the same cycle, as a double-rate
        // pumped single-write RAM would.
        multiport_ram_2r2w_store #(
            .P_DEPTH (P_MEM_DEPTH),
            .P_WIDTH (P_MEM_WIDTH),
            .P_AW    (P_ADDR_WIDTH),
            .P_SIM   (P_SIM != 0)
        ) u_bank (
            .i_clk     (clk_i),
            .i_rst     (rst_i),
            .i_wa_en   (w_wa_en),
            .i_wa_addr (wra_addr_i),
            .i_wa_data (wra_data_i),
            .i_wb_en   (w_wb_en),
            .i_wb_addr (wrb_addr_i),
            .i_wb_data (wrb_data_i),
            .i_ra_addr (rda_addr_i),
            .i_rb_addr (rdb_addr_i),
            .o_ra_data (w_rda_store),
            .o_rb_data (w_rdb_store)
        );
    end else if (P_METHOD == "LVT") begin : g_lvt
        logic [P_MEM_WIDTH-1:0] w_a_ra;
        logic [P_MEM_WIDTH-1:0] w_a_rb;
        logic [P_MEM_WIDTH-1:0] w_b_ra;
        logic [P_MEM_WIDTH-1:0] w_b_rb;
        logic [P_MEM_DEPTH-1:0] r_lvt;   // 1 = bank B holds the live word

        multiport_ram_2r2w_store #(
            .P_DEPTH (P_MEM_DEPTH),
            .P_WIDTH (P_MEM_WIDTH),
            .P_AW    (P_ADDR_WIDTH),
            .P_SIM   (P_SIM != 0)
        ) u_bank_a (
            .i_clk     (clk_i),
            .i_rst     (rst_i),
            .i_wa_en   (w_wa_en),
            .i_wa_addr (wra_addr_i),
            .i_wa_data (wra_data_i),
            .i_wb_en   (1'b0),
            .i_wb_addr ('0),
            .i_wb_data ('0),
            .i_ra_addr (rda_addr_i),
            .i_rb_addr (rdb_addr_i),
            .o_ra_data (w_a_ra),
            .o_rb_data (w_a_rb)
        );

        multiport_ram_2r2w_store #(
            .P_DEPTH (P_MEM_DEPTH),
            .P_WIDTH (P_MEM_WIDTH),
            .P_AW    (P_ADDR_WIDTH),
            .P_SIM   (P_SIM != 0)
        ) u_bank_b (
            .i_clk     (clk_i),
            .i_rst     (rst_i),
            .i_wa_en   (w_wb_en),
            .i_wa_addr (wrb_addr_i),
            .i_wa_data (wrb_data_i),
            .i_wb_en   (1'b0),
            .i_wb_addr ('0),
            .i_wb_data ('0),
            .i_ra_addr (rda_addr_i),
            .i_rb_addr (rdb_addr_i),
            .o_ra_data (w_b_ra),
            .o_rb_data (w_b_rb)
        );

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_lvt <= '0;
            end else begin
                if (w_wa_en) r_lvt[wra_addr_i] <= 1'b0;
                if (w_wb_en) r_lvt[wrb_addr_i] <= 1'b1;
            end
        end

        assign w_rda_store = r_lvt[rda_addr_i] ? w_b_ra : w_a_ra;
        assign w_rdb_store = r_lvt[rdb_addr_i] ? w_b_rb : w_a_rb;
    end else begin : g_bad_method
        $fatal(1, "multiport_ram_2r2w: illegal P_METHOD \"%s\"", P_METHOD);
    end

    // Write-first bypass: data being written this edge overrides the stored
    // word. Out-of-range reads collapse to zero last.
    // NOTE: each always_comb output is given a default first so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        w_rda_next = w_rda_store;
        if (w_wa_en && (wra_addr_i == rda_addr_i)) w_rda_next = wra_data_i;
        if (w_wb_en && (wrb_addr_i == rda_addr_i)) w_rda_next = wrb_data_i;
        if (!w_rda_ok) w_rda_next = '0;
    end

    always_comb begin
        w_rdb_next = w_rdb_store;
        if (w_wa_en && (wra_addr_i == rdb_addr_i)) w_rdb_next = wra_data_i;
        if (w_wb_en && (wrb_addr_i == rdb_addr_i)) w_rdb_next = wrb_data_i;
        if (!w_rdb_ok) w_rdb_next = '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rda_data_o <= '0;
            rdb_data_o <= '0;
        end else begin
            rda_data_o <= w_rda_next;
            rdb_data_o <= w_rdb_next;
        end
    end

endmodule

// File: tb/tb_multiport_ram_2r2w.sv
// -----------------------------------------------------------------------------
// tb_multiport_ram_2r2w
//
// Drives one 2R2W stimulus stream into six instances of multiport_ram_2r2w:
// four 2048x32 builds (MULTIPUMPED/LVT x P_SIM 0/1), a 2048x9 build fed the
// low data bits, and a 1000x32 build fed the low 10 address bits (so part of
// the stream lands on invalid addresses). Expected read data is computed from
// behavioural models when the stimulus is applied, queued, and compared after
// the next rising edge.
// -----------------------------------------------------------------------------
module tb_multiport_ram_2r2w;

    typedef struct packed {
        logic [31:0] a;    // expected port A, 2048-deep builds
        logic [31:0] b;    // expected port B, 2048-deep builds
        logic [31:0] ka;   // expected port A, 1000-deep build
        logic [31:0] kb;   // expected port B, 1000-deep build
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] rda_addr = '0;
    logic [10:0] rdb_addr = '0;
    logic [10:0] wra_addr = '0;
    logic [31:0] wra_data = '0;
    logic        wra_valid = 1'b0;
    logic [10:0] wrb_addr = '0;
    logic [31:0] wrb_data = '0;
    logic        wrb_valid = 1'b0;

    logic [31:0] mp1_a, mp1_b, mp0_a, mp0_b, lv1_a, lv1_b, lv0_a, lv0_b;
    logic [8:0]  w9_a, w9_b;
    logic [31:0] k_a, k_b;

    logic [31:0] m_big [2048];
    logic [31:0] m_k   [1024];
    exp_t        sb [$];
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    multiport_ram_2r2w #(.P_MEM_DEPTH(2048), .P_MEM_WIDTH(32), .P_SIM(1), .P_METHOD("MULTIPUMPED")) u_mp1 (
        .clk_i(clk), .rst_i(rst), .rda_addr_i(rda_addr), .rdb_addr_i(rdb_addr),
        .rda_data_o(mp1_a), .rdb_data_o(mp1_b),
        .wra_addr_i(wra_addr), .wra_data_i(wra_data), .wra_valid_i(wra_valid),
        .wrb_addr_i(wrb_addr), .wrb_data_i(wrb_data), .wrb_valid_i(wrb_valid));

    multiport_ram_2r2w #(.P_MEM_DEPTH(2048), .P_MEM_WIDTH(32), .P_SIM(0), .P_METHOD("MULTIPUMPED")) u_mp0 (
        .clk_i(clk), .rst_i(rst), .rda_addr_i(rda_addr), .rdb_addr_i(rdb_addr),
        .rda_data_o(mp0_a), .rdb_data_o(mp0_b),
        .wra_addr_i(wra_addr), .wra_data_i(wra_data), .wra_valid_i(wra_valid),
        .wrb_addr_i(wrb_addr), .wrb_data_i(wrb_data), .wrb_valid_i(wrb_valid));

    multiport_ram_2r2w #(.P_MEM_DEPTH(2048), .P_MEM_WIDTH(32), .P_SIM(1), .P_METHOD("LVT")) u_lv1 (
        .clk_i(clk), .rst_i(rst), .rda_addr_i(rda_addr), .rdb_addr_i(rdb_addr),
        .rda_data_o(lv1_a), .rdb_data_o(lv1_b),
        .wra_addr_i(wra_addr), .wra_data_i(wra_data), .wra_valid_i(wra_valid),
        .wrb_addr_i(wrb_addr), .wrb_data_i(wrb_data), .wrb_valid_i(wrb_valid));

    multiport_ram_2r2w #(.P_MEM_DEPTH(2048), .P_MEM_WIDTH(32), .P_SIM(0), .P_METHOD("LVT")) u_lv0 (
        .clk_i(clk), .rst_i(rst), .rda_addr_i(rda_addr), .rdb_addr_i(rdb_addr),
        .rda_data_o(lv0_a), .rdb_data_o(lv0_b),
        .wra_addr_i(wra_addr), .wra_data_i(wra_data), .wra_valid_i(wra_valid),
        .wrb_addr_i(wrb_addr), .wrb_data_i(wrb_data), .wrb_valid_i(wrb_valid));

    multiport_ram_2r2w #(.P_MEM_DEPTH(2048), .P_MEM_WIDTH(9), .P_SIM(1), .P_METHOD("MULTIPUMPED")) u_w9 (
        .clk_i(clk), .rst_i(rst), .rda_addr_i(rda_addr), .rdb_addr_i(rdb_addr),
        .rda_data_o(w9_a), .rdb_data_o(w9_b),
        .wra_addr_i(wra_addr), .wra_data_i(wra_data[8:0]), .wra_valid_i(wra_valid),
        .wrb_addr_i(wrb_addr), .wrb_data_i(wrb_data[8:0]), .wrb_valid_i(wrb_valid));

    multiport_ram_2r2w #(.P_MEM_DEPTH(1000), .P_MEM_WIDTH(32), .P_SIM(1), .P_METHOD("LVT")) u_k (
        .clk_i(clk), .rst_i(rst), .rda_addr_i(rda_addr[9:0]), .rdb_addr_i(rdb_addr[9:0]),
        .rda_data_o(k_a), .rdb_data_o(k_b),
        .wra_addr_i(wra_addr[9:0]), .wra_data_i(wra_data), .wra_valid_i(wra_valid),
        .wrb_addr_i(wrb_addr[9:0]), .wrb_data_i(wrb_data), .wrb_valid_i(wrb_valid));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_models();
        for (int i = 0; i < 2048; i++) m_big[i] = '0;
        for (int i = 0; i < 1024; i++) m_k[i] = '0;
    endtask

    // Write-first read of the 2048-deep model, using the stimulus being applied.
    function automatic logic [31:0] exp_big(input logic [10:0] ra);
        logic [31:0] v;
        v = m_big[ra];
        if (wra_valid && wra_addr == ra) v = wra_data;
        if (wrb_valid && wrb_addr == ra) v = wrb_data;
        return v;
    endfunction

    // Same for the 1000-deep build, which sees only the low 10 address bits.
    function automatic logic [31:0] exp_k(input logic [9:0] ra);
        logic [31:0] v;
        if (ra >= 10'd1000) return '0;
        v = m_k[ra];
        if (wra_valid && wra_addr[9:0] == ra) v = wra_data;
        if (wrb_valid && wrb_addr[9:0] == ra) v = wrb_data;
        return v;
    endfunction

    task automatic compare_all(input exp_t e);
        check("mp1_a", mp1_a, e.a);  check("mp1_b", mp1_b, e.b);
        check("mp0_a", mp0_a, e.a);  check("mp0_b", mp0_b, e.b);
        check("lv1_a", lv1_a, e.a);  check("lv1_b", lv1_b, e.b);
        check("lv0_a", lv0_a, e.a);  check("lv0_b", lv0_b, e.b);
        check("w9_a", {23'd0, w9_a}, {23'd0, e.a[8:0]});
        check("w9_b", {23'd0, w9_b}, {23'd0, e.b[8:0]});
        check("k_a", k_a, e.ka);     check("k_b", k_b, e.kb);
    endtask

    // Apply one cycle of stimulus, queue the expectation, clock, then compare.
    task automatic step(input logic [10:0] ra, input logic [10:0] rb,
                        input logic wav, input logic [10:0] wa, input logic [31:0] da,
                        input logic wbv, input logic [10:0] wb, input logic [31:0] db);
        exp_t e;
        rda_addr = ra;   rdb_addr = rb;
        wra_valid = wav; wra_addr = wa; wra_data = da;
        wrb_valid = wbv; wrb_addr = wb; wrb_data = db;
        e.a  = exp_big(ra);
        e.b  = exp_big(rb);
        e.ka = exp_k(ra[9:0]);
        e.kb = exp_k(rb[9:0]);
        sb.push_back(e);
        @(posedge clk);
        if (wav) m_big[wa] = da;
        if (wbv) m_big[wb] = db;
        if (wav && wa[9:0] < 10'd1000) m_k[wa[9:0]] = da;
        if (wbv && wb[9:0] < 10'd1000) m_k[wb[9:0]] = db;
        #1;
        compare_all(sb.pop_front());
    endtask

    task automatic idle_read(input logic [10:0] ra, input logic [10:0] rb);
        step(ra, rb, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        logic [10:0] r_a, r_b, w_a, w_b;
        clear_models();

        // Reset with a write presented: it must be discarded.
        rst = 1'b1;
        wra_valid = 1'b1; wra_addr = 11'd5; wra_data = 32'hDEADBEEF;
        rda_addr = 11'd5; rdb_addr = 11'd5;
        repeat (3) @(posedge clk);
        #1;
        compare_all('0);
        wra_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        idle_read(11'd5, 11'd5);
        check("rst_discard", mp1_a, 32'h0);

        // Dual independent writes, then reads.
        step(11'd0, 11'd0, 1'b1, 11'd3, 32'h11111111, 1'b1, 11'd7, 32'h22222222);
        idle_read(11'd3, 11'd7);
        check("dual_a", mp1_a, 32'h11111111);
        check("dual_b", lv0_b, 32'h22222222);
        idle_read(11'd7, 11'd7);
        check("same_rd", lv1_a, 32'h22222222);

        // Write-write collision, then single-port writes.
        step(11'd0, 11'd0, 1'b1, 11'd10, 32'hAAAA0000, 1'b1, 11'd10, 32'hBBBB0000);
        idle_read(11'd10, 11'd10);
        check("coll", mp0_a, 32'hBBBB0000);
        step(11'd0, 11'd0, 1'b0, 11'd11, 32'hCCCC0000, 1'b1, 11'd12, 32'hDDDD0000);
        step(11'd0, 11'd0, 1'b1, 11'd13, 32'hEEEE0000, 1'b0, 11'd14, 32'hFFFF0000);
        idle_read(11'd11, 11'd12);
        check("b_only_a", lv0_a, 32'h0);
        check("b_only_b", lv0_b, 32'hDDDD0000);
        idle_read(11'd13, 11'd14);
        check("a_only_a", lv1_a, 32'hEEEE0000);
        check("a_only_b", lv1_b, 32'h0);

        // Read-during-write forwarding.
        step(11'd0, 11'd0, 1'b1, 11'd20, 32'h5, 1'b0, '0, '0);
        step(11'd20, 11'd0, 1'b1, 11'd20, 32'h6, 1'b0, '0, '0);
        check("rdw_a", mp1_a, 32'h6);
        step(11'd20, 11'd20, 1'b1, 11'd20, 32'h7, 1'b1, 11'd20, 32'h8);
        check("rdw_coll_a", lv1_a, 32'h8);
        check("rdw_coll_b", mp0_b, 32'h8);

        // 9-bit build: all-ones word, exact 1-cycle latency.
        step(11'd0, 11'd0, 1'b1, 11'd100, 32'h000001FF, 1'b0, '0, '0);
        idle_read(11'd100, 11'd100);
        check("w9_ones", {23'd0, w9_a}, 32'h1FF);

        // Fill then stream back-to-back reads without bubbles.
        for (int i = 0; i < 8; i++)
            step(11'd0, 11'd0, 1'b1, 11'(30 + i), 32'h300 + i, 1'b1, 11'(40 + i), 32'h400 + i);
        for (int i = 0; i < 8; i++) begin
            idle_read(11'(30 + i), 11'(40 + i));
            check("stream_a", mp1_a, 32'h300 + i);
            check("stream_b", lv0_b, 32'h400 + i);
        end

        // Depth-1000 build: address 1010 is invalid.
        step(11'd0, 11'd0, 1'b1, 11'd1010, 32'h12345678, 1'b0, '0, '0);
        idle_read(11'd1010, 11'd999);
        check("k_oob_rd", k_a, 32'h0);
        check("big_1010", mp1_a, 32'h12345678);

        // Reset asserted between edges with a write pending.
        step(11'd0, 11'd0, 1'b1, 11'd50, 32'h00001234, 1'b0, '0, '0);
        idle_read(11'd50, 11'd50);
        wrb_valid = 1'b1; wrb_addr = 11'd50; wrb_data = 32'h5555AAAA;
        #2;
        rst = 1'b1;
        #1;
        compare_all('0);
        clear_models();
        @(negedge clk);
        wrb_valid = 1'b0;
        rst = 1'b0;
        idle_read(11'd50, 11'd3);
        check("midrst", lv1_a, 32'h0);

        // Random stream with frequent collisions and invalid depth-1000 hits.
        for (int n = 0; n < 10000; n++) begin
            r_a = ($urandom_range(0, 4) == 0) ? 11'($urandom_range(0, 2047)) : 11'($urandom_range(992, 1007));
            r_b = ($urandom_range(0, 4) == 0) ? 11'($urandom_range(0, 2047)) : 11'($urandom_range(992, 1007));
            w_a = ($urandom_range(0, 4) == 0) ? 11'($urandom_range(0, 2047)) : 11'($urandom_range(992, 1007));
            w_b = ($urandom_range(0, 4) == 0) ? 11'($urandom_range(0, 2047)) : 11'($urandom_range(992, 1007));
            step(r_a, r_b, 1'($urandom_range(0, 1)), w_a, $urandom,
                 1'($urandom_range(0, 1)), w_b, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
